// File: rtl/led_sequencer.sv
// LED pattern sequencer: a prescaler sets the step rate and each step advances a
// position through rotate-up, rotate-down, bounce or fill-bar patterns on N_CH pins.
module led_sequencer #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned STEP_CYCLES = 6_250_000,
   parameter int unsigned CNT_W       = 25
) (
   input  logic            SCK,
   input  logic            RST,
   input  logic            EN,
   input  logic            CLR,
   input  logic [1:0]      MODE,
   output logic [N_CH-1:0] PIN,
   output logic            STEP,
   output logic            WRAP
);

   localparam int unsigned     POS_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_CH - 1);
   localparam logic [POS_W-1:0] POS_PEN  = POS_W'(N_CH - 2);
   localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [N_CH-1:0]  PIN_ALL  = '1;
   localparam logic [N_CH-1:0]  PIN_RST  = N_CH'(1);

   localparam logic [1:0] MODE_UP     = 2'b00;
   localparam logic [1:0] MODE_DOWN   = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic [1:0] MODE_FILL   = 2'b11;

   logic [CNT_W-1:0] r_count;
   logic [POS_W-1:0] r_pos;
   logic             r_dir;
   logic [N_CH-1:0]  r_pin;
   logic             r_step;
   logic             r_wrap;

   logic             w_term;
   logic [POS_W-1:0] w_pos_nxt;
   logic             w_dir_nxt;
   logic             w_wrap_nxt;
   logic [N_CH-1:0]  w_pin_nxt;

   assign w_term = (r_count == CNT_TERM);

   // Candidate position/direction/output for the next step, from the current MODE
   always_comb begin
      w_pos_nxt  = r_pos;
      w_dir_nxt  = r_dir;
      w_wrap_nxt = 1'b0;
      case (MODE)
         MODE_DOWN: begin
            w_pos_nxt  = (r_pos == '0) ? POS_LAST : r_pos - POS_ONE;
            w_wrap_nxt = (r_pos == '0);
         end
         MODE_BOUNCE: begin
            if (!r_dir) begin
               if (r_pos == POS_LAST) begin
                  w_dir_nxt = 1'b1;
                  w_pos_nxt = POS_PEN;
               end else begin
                  w_pos_nxt = r_pos + POS_ONE;
               end
            end else begin
               if (r_pos == '0) begin
                  w_dir_nxt = 1'b0;
                  w_pos_nxt = POS_ONE;
               end else begin
                  w_pos_nxt = r_pos - POS_ONE;
               end
            end
            w_wrap_nxt = (r_pos == POS_ONE) && (w_pos_nxt == '0);
         end
         default: begin
            w_pos_nxt  = (r_pos == POS_LAST) ? '0 : r_pos + POS_ONE;
            w_wrap_nxt = (r_pos == POS_LAST);
         end
      endcase
      // Double shift keeps the fill mask correct when POS is the top bit
      if (MODE == MODE_FILL) begin
         w_pin_nxt = ~((PIN_ALL << w_pos_nxt) << 1);
      end else begin
         w_pin_nxt = PIN_RST << w_pos_nxt;
      end
   end

   always_ff @(posedge SCK or negedge RST) begin
      if (!RST) begin
         r_count <= '0;
         r_pos   <= '0;
         r_dir   <= 1'b0;
         r_pin   <= PIN_RST;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (CLR) begin
         r_count <= '0;
         r_pos   <= '0;
         r_dir   <= 1'b0;
         r_pin   <= PIN_RST;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (!EN) begin
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (w_term) begin
         r_count <= '0;
         r_pos   <= w_pos_nxt;
         r_dir   <= w_dir_nxt;
         r_pin   <= w_pin_nxt;
         r_step  <= 1'b1;
         r_wrap  <= w_wrap_nxt;
      end else begin
         r_count <= r_count + CNT_ONE;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
      end
   end

   assign PIN  = r_pin;
   assign STEP = r_step;
   assign WRAP = r_wrap;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench: three sequencer configurations share one stimulus stream and
// are compared every cycle against a pattern-level reference model.
module tb_led_sequencer;

   logic       SCK = 1'b0;
   logic       RST = 1'b0;
   logic       EN  = 1'b1;
   logic       CLR = 1'b0;
   logic [1:0] MODE = 2'b00;

   logic [3:0] pin_a;
   logic [7:0] pin_b;
   logic [3:0] pin_c;
   logic       step_a, wrap_a, step_b, wrap_b, step_c, wrap_c;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 SCK = ~SCK;

   led_sequencer #(.N_CH(4), .STEP_CYCLES(4), .CNT_W(2)) u_a (
      .SCK(SCK), .RST(RST), .EN(EN), .CLR(CLR), .MODE(MODE),
      .PIN(pin_a), .STEP(step_a), .WRAP(wrap_a));

   led_sequencer #(.N_CH(8), .STEP_CYCLES(3), .CNT_W(2)) u_b (
      .SCK(SCK), .RST(RST), .EN(EN), .CLR(CLR), .MODE(MODE),
      .PIN(pin_b), .STEP(step_b), .WRAP(wrap_b));

   led_sequencer #(.N_CH(4), .STEP_CYCLES(1), .CNT_W(1)) u_c (
      .SCK(SCK), .RST(RST), .EN(EN), .CLR(CLR), .MODE(MODE),
      .PIN(pin_c), .STEP(step_c), .WRAP(wrap_c));

   typedef struct {
      int          cnt;
      int          pos;
      int          dir;
      logic [31:0] pin;
      bit          step;
      bit          wrap;
   } model_t;

   model_t m_a, m_b, m_c;
   logic [33:0] q_a[$];
   logic [33:0] q_b[$];
   logic [33:0] q_c[$];

   function automatic model_t m_reset();
      model_t s;
      s.cnt = 0; s.pos = 0; s.dir = 0; s.pin = 32'd1; s.step = 1'b0; s.wrap = 1'b0;
      return s;
   endfunction

   // Pattern-level behaviour for one rising edge
   function automatic model_t m_next(model_t s, int n, int sc, bit en, bit clr, int mode);
      model_t r = s;
      int old;
      if (clr) return m_reset();
      r.step = 1'b0;
      r.wrap = 1'b0;
      if (!en) return r;
      if (s.cnt != sc - 1) begin
         r.cnt = s.cnt + 1;
         return r;
      end
      r.cnt = 0;
      old   = s.pos;
      if (mode == 1) begin
         r.pos  = (s.pos + n - 1) % n;
         r.wrap = (old == 0);
      end else if (mode == 2) begin
         if (s.dir == 0) begin
            if (s.pos == n - 1) begin r.dir = 1; r.pos = n - 2; end
            else r.pos = s.pos + 1;
         end else begin
            if (s.pos == 0) begin r.dir = 0; r.pos = 1; end
            else r.pos = s.pos - 1;
         end
         r.wrap = (old == 1) && (r.pos == 0);
      end else begin
         r.pos  = (s.pos + 1) % n;
         r.wrap = (old == n - 1);
      end
      if (mode == 3) r.pin = 32'((64'd1 << (r.pos + 1)) - 64'd1);
      else           r.pin = 32'd1 << r.pos;
      r.step = 1'b1;
      return r;
   endfunction

   task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got pin=%h step=%b wrap=%b, expected pin=%h step=%b wrap=%b",
                  name, act[33:2], act[1], act[0], exp[33:2], exp[1], exp[0]);
      end
   endtask

   // Advance every model by one edge with the current inputs and queue the expectation
   task automatic apply();
      m_a = m_next(m_a, 4, 4, EN, CLR, int'(MODE));
      m_b = m_next(m_b, 8, 3, EN, CLR, int'(MODE));
      m_c = m_next(m_c, 4, 1, EN, CLR, int'(MODE));
      q_a.push_back({m_a.pin, m_a.step, m_a.wrap});
      q_b.push_back({m_b.pin, m_b.step, m_b.wrap});
      q_c.push_back({m_c.pin, m_c.step, m_c.wrap});
   endtask

   task automatic cycle(input bit en, input bit clr, input int mode);
      @(negedge SCK);
      #1;
      EN   = en;
      CLR  = clr;
      MODE = 2'(mode);
      apply();
   endtask

   task automatic run(input int n, input int mode);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, mode);
   endtask

   // Reset lands between edges; outputs must change without waiting for SCK
   task automatic do_reset();
      @(negedge SCK);
      #3;
      RST = 1'b0;
      #1;
      check("rst_async_a", {32'(pin_a), step_a, wrap_a}, {32'd1, 2'b00});
      check("rst_async_b", {32'(pin_b), step_b, wrap_b}, {32'd1, 2'b00});
      check("rst_async_c", {32'(pin_c), step_c, wrap_c}, {32'd1, 2'b00});
      m_a = m_reset();
      m_b = m_reset();
      m_c = m_reset();
      @(negedge SCK);
      #1;
      RST = 1'b1;
      apply();
   endtask

   initial begin : monitor
      forever begin
         @(negedge SCK);
         if (q_a.size() > 0) check("cfg_a", {32'(pin_a), step_a, wrap_a}, q_a.pop_front());
         if (q_b.size() > 0) check("cfg_b", {32'(pin_b), step_b, wrap_b}, q_b.pop_front());
         if (q_c.size() > 0) check("cfg_c", {32'(pin_c), step_c, wrap_c}, q_c.pop_front());
      end
   end

   initial begin : stimulus
      m_a = m_reset();
      m_b = m_reset();
      m_c = m_reset();
      repeat (2) @(negedge SCK);
      do_reset();
      run(17, 0);
      do_reset();
      run(21, 1);
      do_reset();
      run(32, 2);
      do_reset();
      run(16, 2);
      run(8, 0);
      do_reset();
      run(20, 3);
      do_reset();
      run(40, 3);
      do_reset();
      run(2, 0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 0);
      run(12, 0);
      do_reset();
      run(8, 0);
      cycle(1'b1, 1'b1, 0);
      run(10, 0);
      do_reset();
      run(3, 0);
      cycle(1'b1, 1'b1, 0);
      run(6, 0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                  ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : int'(MODE));
         end
      end
      @(negedge SCK);
      #2;
      n_checks++;
      if (q_a.size() + q_b.size() + q_c.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, expected 0", q_a.size() + q_b.size() + q_c.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
